// File: rtl/id_ex_stage_reg_pkg.sv
// id_ex_stage_reg_pkg: shared widths, FSM encoding and ID/EX field bundle
package id_ex_stage_reg_pkg;
    localparam int REG_W   = 3;
    localparam int DATA_W  = 16;
    localparam int ALUOP_W = 5;
    localparam int CNT_W   = 16;
    typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, HALT = 2'd2} state_t;
    typedef struct packed {
        logic               valid;
        logic               write_reg;
        logic               mem_read;
        logic               mem_write;
        logic               halt;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic               rs_valid;
        logic               rt_valid;
        logic               rd_valid;
        logic [ALUOP_W-1:0] alu_op;
        logic [DATA_W-1:0]  read_data1;
        logic [DATA_W-1:0]  read_data2;
        logic [DATA_W-1:0]  imm;
        logic [DATA_W-1:0]  pc_inc;
    } id_ex_t;
    localparam id_ex_t BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// load_use_detect: flags an ID instruction reading the register a load in ID/EX is about to write
module load_use_detect
    import id_ex_stage_reg_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic             ex_write_reg,
    input  logic             ex_rd_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic             rs_valid,
    input  logic [REG_W-1:0] rs,
    input  logic             rt_valid,
    input  logic [REG_W-1:0] rt,
    output logic             hazard
);
    assign hazard = ex_valid & ex_mem_read & ex_write_reg & ex_rd_valid & id_valid &
                    ((rs_valid & (rs == ex_rd)) | (rt_valid & (rt == ex_rd)));
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use stall, flush bubbles and halt
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               Valid_id,
    input  logic               WriteReg_id,
    input  logic               MemRead_id,
    input  logic               MemWrite_id,
    input  logic               Halt_id,
    input  logic [REG_W-1:0]   Rs_id,
    input  logic [REG_W-1:0]   Rt_id,
    input  logic [REG_W-1:0]   Rd_id,
    input  logic               Rs_valid_id,
    input  logic               Rt_valid_id,
    input  logic               Rd_valid_id,
    input  logic [ALUOP_W-1:0] ALUOp_id,
    input  logic [DATA_W-1:0]  ReadData1_id,
    input  logic [DATA_W-1:0]  ReadData2_id,
    input  logic [DATA_W-1:0]  Imm_id,
    input  logic [DATA_W-1:0]  PCInc_id,
    input  logic               flush,
    input  logic               stall_ext,
    output logic               Valid_id_ex,
    output logic               WriteReg_id_ex,
    output logic               MemRead_id_ex,
    output logic               MemWrite_id_ex,
    output logic               Halt_id_ex,
    output logic [REG_W-1:0]   Rs_id_ex,
    output logic [REG_W-1:0]   Rt_id_ex,
    output logic [REG_W-1:0]   Rd_id_ex,
    output logic               Rs_valid_id_ex,
    output logic               Rt_valid_id_ex,
    output logic               Rd_valid_id_ex,
    output logic [ALUOP_W-1:0] ALUOp_id_ex,
    output logic [DATA_W-1:0]  ReadData1_id_ex,
    output logic [DATA_W-1:0]  ReadData2_id_ex,
    output logic [DATA_W-1:0]  Imm_id_ex,
    output logic [DATA_W-1:0]  PCInc_id_ex,
    output logic               stall_if_id,
    output logic               halted,
    output logic [CNT_W-1:0]   bubble_cnt
);
    state_t state;
    id_ex_t d, q;
    logic   hazard, lu;
    assign d = {Valid_id, WriteReg_id, MemRead_id, MemWrite_id, Halt_id, Rs_id, Rt_id, Rd_id,
                Rs_valid_id, Rt_valid_id, Rd_valid_id, ALUOp_id, ReadData1_id, ReadData2_id,
                Imm_id, PCInc_id};
    assign {Valid_id_ex, WriteReg_id_ex, MemRead_id_ex, MemWrite_id_ex, Halt_id_ex, Rs_id_ex,
            Rt_id_ex, Rd_id_ex, Rs_valid_id_ex, Rt_valid_id_ex, Rd_valid_id_ex, ALUOp_id_ex,
            ReadData1_id_ex, ReadData2_id_ex, Imm_id_ex, PCInc_id_ex} = q;
    load_use_detect u_lu (
        .ex_valid    (q.valid),
        .ex_mem_read (q.mem_read),
        .ex_write_reg(q.write_reg),
        .ex_rd_valid (q.rd_valid),
        .ex_rd       (q.rd),
        .id_valid    (Valid_id),
        .rs_valid    (Rs_valid_id),
        .rs          (Rs_id),
        .rt_valid    (Rt_valid_id),
        .rt          (Rt_id),
        .hazard      (hazard)
    );
    // the stalled instruction is re-presented in LU_STALL, so the hazard only counts in RUN
    assign lu          = hazard & (state == RUN);
    assign stall_if_id = lu | stall_ext | (state == HALT);
    assign halted      = (state == HALT);
    // pipeline register and FSM: reset > halt hold > external stall > bubble > load
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            q          <= BUBBLE;
            bubble_cnt <= '0;
        end else if (state == HALT || stall_ext) begin
            state <= state;
        end else if (flush || lu) begin
            q          <= BUBBLE;
            bubble_cnt <= (bubble_cnt == '1) ? bubble_cnt : bubble_cnt + 1'b1;
            state      <= flush ? RUN : LU_STALL;
        end else begin
            q     <= d;
            state <= (Valid_id && Halt_id) ? HALT : RUN;
        end
    end
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: randomized and directed checks against a behavioural model
module tb_id_ex_stage_reg;
    typedef struct packed {
        logic        valid, write_reg, mem_read, mem_write, halt;
        logic [2:0]  rs, rt, rd;
        logic        rs_valid, rt_valid, rd_valid;
        logic [4:0]  alu_op;
        logic [15:0] rd1, rd2, imm, pc_inc;
    } vec_t;

    logic clk = 0, rst = 0, flush = 0, stall_ext = 0;
    vec_t in = '0, got, m = '0;
    logic        Valid_id_ex, WriteReg_id_ex, MemRead_id_ex, MemWrite_id_ex, Halt_id_ex;
    logic [2:0]  Rs_id_ex, Rt_id_ex, Rd_id_ex;
    logic        Rs_valid_id_ex, Rt_valid_id_ex, Rd_valid_id_ex;
    logic [4:0]  ALUOp_id_ex;
    logic [15:0] ReadData1_id_ex, ReadData2_id_ex, Imm_id_ex, PCInc_id_ex, bubble_cnt;
    logic        stall_if_id, halted;

    bit          m_halt = 0, m_lus = 0;
    int          m_cnt = 0;
    int          vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst),
        .Valid_id(in.valid), .WriteReg_id(in.write_reg), .MemRead_id(in.mem_read),
        .MemWrite_id(in.mem_write), .Halt_id(in.halt),
        .Rs_id(in.rs), .Rt_id(in.rt), .Rd_id(in.rd),
        .Rs_valid_id(in.rs_valid), .Rt_valid_id(in.rt_valid), .Rd_valid_id(in.rd_valid),
        .ALUOp_id(in.alu_op), .ReadData1_id(in.rd1), .ReadData2_id(in.rd2),
        .Imm_id(in.imm), .PCInc_id(in.pc_inc),
        .flush(flush), .stall_ext(stall_ext),
        .Valid_id_ex(Valid_id_ex), .WriteReg_id_ex(WriteReg_id_ex), .MemRead_id_ex(MemRead_id_ex),
        .MemWrite_id_ex(MemWrite_id_ex), .Halt_id_ex(Halt_id_ex),
        .Rs_id_ex(Rs_id_ex), .Rt_id_ex(Rt_id_ex), .Rd_id_ex(Rd_id_ex),
        .Rs_valid_id_ex(Rs_valid_id_ex), .Rt_valid_id_ex(Rt_valid_id_ex), .Rd_valid_id_ex(Rd_valid_id_ex),
        .ALUOp_id_ex(ALUOp_id_ex), .ReadData1_id_ex(ReadData1_id_ex), .ReadData2_id_ex(ReadData2_id_ex),
        .Imm_id_ex(Imm_id_ex), .PCInc_id_ex(PCInc_id_ex),
        .stall_if_id(stall_if_id), .halted(halted), .bubble_cnt(bubble_cnt)
    );

    assign got = {Valid_id_ex, WriteReg_id_ex, MemRead_id_ex, MemWrite_id_ex, Halt_id_ex,
                  Rs_id_ex, Rt_id_ex, Rd_id_ex, Rs_valid_id_ex, Rt_valid_id_ex, Rd_valid_id_ex,
                  ALUOp_id_ex, ReadData1_id_ex, ReadData2_id_ex, Imm_id_ex, PCInc_id_ex};

    task automatic chk(input string tag, input logic [85:0] g, input logic [85:0] e);
        vectors++;
        assert (g === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, g, e);
        end
    endtask

    task automatic check_outs();
        chk("id_ex_fields", got, m);
        chk("halted", halted, m_halt);
        chk("bubble_cnt", bubble_cnt, m_cnt[15:0]);
    endtask

    // one clock: check stall before the edge, advance the model, check registered outputs
    task automatic step(input bit c);
        bit lu;
        #1;
        lu = !m_halt && !m_lus && m.valid && m.mem_read && m.write_reg && m.rd_valid && in.valid &&
             ((in.rs_valid && in.rs == m.rd) || (in.rt_valid && in.rt == m.rd));
        if (c) chk("stall_if_id", stall_if_id, lu || stall_ext || m_halt);
        @(posedge clk);
        if (!rst) begin
            m = '0; m_cnt = 0; m_halt = 0; m_lus = 0;
        end else if (m_halt || stall_ext) begin
        end else if (flush || lu) begin
            m = '0;
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            m_lus = !flush;
        end else begin
            m = in;
            m_lus = 0;
            m_halt = in.valid && in.halt;
        end
        #1;
        if (c) check_outs();
    endtask

    function automatic vec_t mk(bit v, bit wr, bit mr, bit h, logic [2:0] rs, bit rsv,
                                logic [2:0] rt, bit rtv, logic [2:0] rd, bit rdv);
        vec_t x;
        x.valid = v; x.write_reg = wr; x.mem_read = mr; x.mem_write = 0; x.halt = h;
        x.rs = rs; x.rt = rt; x.rd = rd;
        x.rs_valid = rsv; x.rt_valid = rtv; x.rd_valid = rdv;
        x.alu_op = 5'($urandom);
        x.rd1 = 16'($urandom); x.rd2 = 16'($urandom);
        x.imm = 16'($urandom); x.pc_inc = 16'($urandom);
        return x;
    endfunction

    task automatic rand_in();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        in = r[85:0];
        in.halt = ($urandom_range(0, 15) == 0);
        in.rs = 3'($urandom_range(0, 3)); in.rt = 3'($urandom_range(0, 3)); in.rd = 3'($urandom_range(0, 3));
    endtask

    initial begin
        rst = 0;
        @(posedge clk); #1;
        check_outs();
        chk("reset_stall", stall_if_id, 1'b0);
        rst = 1;
        // load followed by a dependent ADD: one bubble then the ADD
        in = mk(1, 1, 1, 0, 3'd0, 0, 3'd0, 0, 3'd3, 1); step(1);
        in = mk(1, 1, 0, 0, 3'd3, 1, 3'd1, 1, 3'd2, 1); step(1);
        chk("lu_bubble_valid", Valid_id_ex, 1'b0);
        chk("lu_bubble_cnt", bubble_cnt, 16'd1);
        step(1);
        chk("lu_add_loaded", Rs_id_ex, 3'd3);
        // load followed by an independent ADD: no stall
        in = mk(1, 1, 1, 0, 3'd0, 0, 3'd0, 0, 3'd3, 1); step(1);
        in = mk(1, 1, 0, 0, 3'd4, 1, 3'd5, 1, 3'd2, 1); step(1);
        // external stall freezes the register for three cycles
        stall_ext = 1;
        for (int i = 0; i < 3; i++) begin in.imm = 16'($urandom); step(1); end
        stall_ext = 0; in.imm = 16'h1234; step(1);
        // flush coincident with a load-use hazard, then flush under external stall
        in = mk(1, 1, 1, 0, 3'd0, 0, 3'd0, 0, 3'd6, 1); step(1);
        in = mk(1, 1, 0, 0, 3'd0, 0, 3'd6, 1, 3'd1, 1); flush = 1; step(1);
        step(1);
        stall_ext = 1; step(1); step(1);
        stall_ext = 0; flush = 0; step(1);
        // halt then frozen outputs, then reset exits
        in = mk(1, 0, 0, 1, 3'd0, 0, 3'd0, 0, 3'd0, 0); step(1);
        chk("halt_flag", halted, 1'b1);
        for (int i = 0; i < 4; i++) begin rand_in(); flush = 1'($urandom); step(1); end
        flush = 0; rst = 0; step(1);
        rst = 1; in = mk(1, 1, 0, 0, 3'd1, 1, 3'd2, 1, 3'd3, 1); step(1);
        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            rand_in();
            flush = ($urandom_range(0, 7) == 0);
            stall_ext = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 63) != 0);
            step(1);
        end
        // bubble counter saturation
        rst = 0; flush = 0; stall_ext = 0; step(1);
        rst = 1; flush = 1;
        for (int i = 0; i < 65533; i++) step(0);
        for (int i = 0; i < 4; i++) step(1);
        chk("cnt_saturated", bubble_cnt, 16'hFFFF);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  synchronous, active-low reset; sampled on the clk rising edge only.
REQ-003 SHALL: Valid_id, WriteReg_id, MemRead_id, MemWrite_id, Halt_id  in  1 each  decoded ID-stage instruction flags.
REQ-004 SHALL: Rs_id, Rt_id, Rd_id  in  3 each; Rs_valid_id, Rt_valid_id, Rd_valid_id  in  1 each  register IDs and valid bits.
REQ-005 SHALL: ALUOp_id  in  5; ReadData1_id, ReadData2_id, Imm_id, PCInc_id  in  16 each  operand/data fields.
REQ-006 SHALL: flush  in  1  squash the ID-stage instruction (branch resolved taken); stall_ext  in  1  downstream memory stall, freeze.
REQ-007 SHALL: outputs are every REQ-003..005 field registered, suffixed _id_ex, same widths.
REQ-008 SHALL: stall_if_id  out  1  freeze PC and IF/ID; halted  out  1; bubble_cnt  out  16  saturating count of inserted bubbles.

Function
REQ-009 SHALL: load-use hazard lu = Valid_id_ex & MemRead_id_ex & WriteReg_id_ex & Rd_valid_id_ex & Valid_id & ((Rs_valid_id & Rs_id==Rd_id_ex) | (Rt_valid_id & Rt_id==Rd_id_ex)), evaluated only in state RUN.
REQ-010 SHALL: stall_if_id = lu | stall_ext | (state==HALT), combinational, same cycle.
REQ-011 SHALL: per edge, priority rst > state HALT (hold) > stall_ext (hold all) > flush (bubble) > lu (bubble) > load ID fields.
REQ-012 SHALL: bubble = all 1-bit flags and valid bits 0, ALUOp/IDs/data 0.
REQ-013 SHALL: FSM states RUN, LU_STALL, HALT; encoding from shared package.
REQ-014 SHALL: RUN -> LU_STALL on edge where lu=1 and stall_ext=0 and flush=0; bubble inserted, bubble_cnt+1.
REQ-015 SHALL: LU_STALL -> RUN on next edge with stall_ext=0, loading ID fields (or bubble if flush=1); lu not evaluated in LU_STALL; stall_ext=1 holds state.
REQ-016 SHALL: any state except HALT -> HALT on edge where a valid, non-flushed Halt_id is loaded; thereafter register frozen, halted=1; only rst exits.
REQ-017 SHALL: flush bubble also increments bubble_cnt; bubble_cnt saturates at 16'hFFFF, never wraps.
REQ-018 SHALL: flush while stall_ext=1 is ignored; upstream holds flush until stall_ext deasserts.
REQ-019 SHALL: lu with stall_ext=1: hold, no bubble, no count, state unchanged.
REQ-020 SHALL: flush coincident with lu: single bubble, count +1, next state RUN (flush wins).
REQ-021 SHALL: latency ID input -> _id_ex output exactly one clock when not stalled.

Reset
REQ-022 SHALL: rst=0 at an edge -> state RUN, all _id_ex outputs bubble values, bubble_cnt 0, halted 0, regardless of current state or stall_ext.
REQ-023 SHALL: reset asserted mid-stall or in HALT aborts it; first edge after rst=1 loads ID fields normally.

Structure
REQ-024 SHALL: shared package holds FSM state encoding, register-ID width 3, data width 16, ALUOp width 5, bubble_cnt width 16.
REQ-025 SHALL: load-use comparison in one sub-module load_use_detect (pure combinational); pipeline flops and FSM in id_ex_stage_reg.

Verification
REQ-026 SHALL: LW R3 in ID/EX (MemRead,WriteReg,Rd=3 valid), ID ADD Rs=3 valid -> stall_if_id=1 same cycle; next edge Valid_id_ex=0, bubble_cnt=1, state LU_STALL; following edge ADD loaded.
REQ-027 SHALL: same LW R3, ID reads Rs=4, Rt=5 -> stall_if_id=0, ADD loaded in one cycle, bubble_cnt unchanged.
REQ-028 SHALL: stall_ext=1 for 3 cycles with Imm_id changing -> Imm_id_ex constant 3 cycles, stall_if_id=1, then loads latest Imm_id.
REQ-029 SHALL: flush=1 with lu=1 -> one bubble, bubble_cnt +1, state RUN; flush=1 with stall_ext=1 -> no change.
REQ-030 SHALL: Valid_id=1, Halt_id=1 loaded -> halted=1 next cycle, stall_if_id=1, outputs frozen under toggling inputs; rst=0 -> halted=0, Valid_id_ex=0.
REQ-031 SHALL: bubble_cnt preset near 16'hFFFE via repeated flush -> reads 16'hFFFF and stays after further bubbles.
